// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose bits change only through the JK
// characteristic equation; the J/K excitation for the next edge is exported.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_exc,
    output logic [WIDTH-1:0] k_exc,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_target;
    logic [WIDTH-1:0] wrap_target;
    logic [WIDTH-1:0] toggle;
    logic             wrap_set;

    assign tc = en & ~load & (up ? (q == MAX_Q) : (q == '0));

    assign load_target = ({1'b0, din} >= MOD_EXT) ? '0 : din;
    assign wrap_target = up ? '0 : MAX_Q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & (up ? q[i-1] : ~q[i-1]);
        end
    end

    always_comb begin
        j_exc    = '0;
        k_exc    = '0;
        wrap_set = 1'b0;
        if (load) begin
            j_exc = load_target;
            k_exc = ~load_target;
        end else if (en && tc) begin
            j_exc    = wrap_target;
            k_exc    = ~wrap_target;
            wrap_set = 1'b1;
        end else if (en) begin
            j_exc = toggle;
            k_exc = toggle;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= (j_exc & ~q) | (~k_exc & q);
            wrap <= wrap_set;
        end
    end

endmodule
